imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default $size(InstAddr), word-address width of the instruction ROM.
REQ-002 SHALL have parameter DATA_WIDTH, default $size(Inst), ROM word width.
REQ-003 SHALL have parameter LINE_WORDS, default 4, power of two, cache-line burst length in words.
REQ-004 SHALL have port i_clock  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_p0_req  in  1 / i_p0_addr  in  ADDR_WIDTH  cache line-refill request and word address.
REQ-007 SHALL have ports o_p0_gnt  out  1 / o_p0_valid  out  1 / o_p0_last  out  1 / o_p0_data  out  DATA_WIDTH / o_p0_widx  out  log2(LINE_WORDS)  for port-0 grant and returned burst word with its index in the line.
REQ-008 SHALL have ports i_p1_req  in  1 / i_p1_addr  in  ADDR_WIDTH / o_p1_gnt  out  1 / o_p1_valid  out  1 / o_p1_data  out  DATA_WIDTH  for the single-word debug/data read port.
REQ-009 SHALL have ports o_mem_addr  out  ADDR_WIDTH / i_mem_data  in  DATA_WIDTH  to the combinational-read ROM, and o_busy  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, XFER and DRAIN.
REQ-011 In IDLE with any request, SHALL pulse exactly one o_pX_gnt for one cycle, latch that port's address and length (P0: LINE_WORDS, P1: 1), and go to XFER.
REQ-012 In XFER, SHALL drive o_mem_addr = start + cnt and register i_mem_data into the granted port's data output, with valid asserted the following cycle.
REQ-013 SHALL move from XFER to DRAIN after issuing the last address (cnt == len-1), and from DRAIN to IDLE after one cycle.
REQ-014 Latency: for a grant in cycle G, SHALL issue addresses in G+1..G+len, assert valid in G+2..G+len+1, assert o_p0_last with the final P0 word only, and allow the earliest next grant in G+len+2.
REQ-015 SHALL compute P0 burst addresses as {line base, (start index + cnt) mod LINE_WORDS}, wrapping inside the line; o_p0_widx SHALL equal the low address bits of the returned word.
REQ-016 SHALL use round-robin arbitration on simultaneous requests: the port not served last wins; a single requester is always granted.
REQ-017 SHALL sample request and address only in the grant cycle; a requester holds req until gnt, and a req dropped before gnt is ignored.
REQ-018 SHALL hold o_busy high in XFER and DRAIN; o_mem_addr SHALL be 0 in IDLE.
REQ-019 SHALL keep valid, gnt and last low for the non-granted port at all times.

Reset
REQ-020 On i_reset, SHALL force state IDLE, counters 0, all gnt/valid/last/busy low, data outputs 0 and last-served = P1 (so P0 wins first), effective the next cycle, including mid-burst; the aborted burst is not resumed.

Configuration
REQ-021 With IMEM_ARBITER_CWF_EN defined, SHALL start the P0 burst at the requested word (critical word first) and wrap.
REQ-022 Without IMEM_ARBITER_CWF_EN, SHALL clear the low log2(LINE_WORDS) bits of the P0 start, starting at word 0; P1 is unaffected.

Structure
REQ-023 SHALL take InstAddr and Inst from package Types, and add to Types an ArbState enum (IDLE/XFER/DRAIN) and an ArbPort enum (P0/P1).
REQ-024 SHALL take LINE_WORDS default from a constant in Config.sv shared with ICache.
REQ-025 SHALL place arbitration in one sub-module, imem_arb_rr (2-way round-robin picker with last-served register).

Verification (ROM loaded word[a] = a, LINE_WORDS=4)
REQ-026 P0 req addr 0x012 at tick 40, CWF off -> gnt at 40, valid 42..45 with data 0x010,0x011,0x012,0x013, last at 45, widx 0..3.
REQ-027 Same with CWF on -> data 0x012,0x013,0x010,0x011, widx 2,3,0,1.
REQ-028 P0 (0x010) and P1 (0xF11) both req out of reset -> P0 granted first; P1 gnt at G+6, P1 valid at G+8 with data 0xF11.
REQ-029 Both held requesting continuously -> grants alternate P0,P1,P0; no port granted twice in a row.
REQ-030 i_reset asserted during the 2nd P0 valid -> next cycle valid/busy low, state IDLE; a new P0 req afterwards completes a normal 4-word burst.
REQ-031 P1 req 0xFFF -> single valid with data 0xFFF, o_p0_valid stays low, o_busy high for exactly 2 cycles.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: ROM address/word types,
// arbiter FSM state and port identifiers, and the cache-line length.
package imem_arbiter_pkg;

   typedef logic [11:0] InstAddr;
   typedef logic [31:0] Inst;

   // Also used by the instruction cache, so both agree on the refill burst length.
   localparam int CFG_LINE_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } ArbState;

   typedef enum logic {
      P0 = 1'b0,
      P1 = 1'b1
   } ArbPort;

endpackage

// File: rtl/imem_arbiter_rr.sv
// Two-way round-robin picker for imem_arbiter; the last-served register
// resets to P1 so that P0 wins the first contested grant.
module imem_arb_rr
   import imem_arbiter_pkg::*;
(
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_take,
   output logic o_gnt0,
   output logic o_gnt1
);

   ArbPort last_q;
   ArbPort last_d;
   logic   pick0;

   always_comb begin
      if (i_req0 && i_req1) begin
         pick0 = (last_q == P1);
      end else begin
         pick0 = i_req0;
      end
      o_gnt0 = i_take && i_req0 && pick0;
      o_gnt1 = i_take && i_req1 && !pick0;
      last_d = last_q;
      if (o_gnt0) begin
         last_d = P0;
      end else if (o_gnt1) begin
         last_d = P1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         last_q <= P1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a line-refill port (P0) and a single-word read port (P1) onto a
// combinational-read ROM. Define IMEM_ARBITER_CWF_EN for critical-word-first P0 bursts.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = $bits(InstAddr),
   parameter int DATA_WIDTH = $bits(Inst),
   parameter int LINE_WORDS = CFG_LINE_WORDS,
   localparam int IDX_W     = $clog2(LINE_WORDS)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_p0_req,
   input  logic [ADDR_WIDTH-1:0] i_p0_addr,
   output logic                  o_p0_gnt,
   output logic                  o_p0_valid,
   output logic                  o_p0_last,
   output logic [DATA_WIDTH-1:0] o_p0_data,
   output logic [IDX_W-1:0]      o_p0_widx,
   input  logic                  i_p1_req,
   input  logic [ADDR_WIDTH-1:0] i_p1_addr,
   output logic                  o_p1_gnt,
   output logic                  o_p1_valid,
   output logic [DATA_WIDTH-1:0] o_p1_data,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic                  o_busy,
   output ArbState               o_dbg_state
);

   // Handshake: a requester holds req (and addr) until it sees its gnt pulse;
   // req/addr are sampled only in the gnt cycle. valid is a one-cycle
   // qualifier on data with no back-pressure.

   ArbState                 state_q, state_d;
   ArbPort                  port_q, port_d;
   logic [ADDR_WIDTH-1:0]   start_q, start_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic                    p0_valid_q, p0_valid_d;
   logic                    p0_last_q, p0_last_d;
   logic [IDX_W-1:0]        p0_widx_q, p0_widx_d;
   logic [DATA_WIDTH-1:0]   p0_data_q, p0_data_d;
   logic                    p1_valid_q, p1_valid_d;
   logic [DATA_WIDTH-1:0]   p1_data_q, p1_data_d;

   logic                    gnt0, gnt1;
   logic [ADDR_WIDTH-1:0]   p0_start;
   logic [IDX_W-1:0]        word_idx;
   logic [ADDR_WIDTH-1:0]   burst_addr;
   logic                    last_beat;
   logic [ADDR_WIDTH-1:0]   mem_addr;

   imem_arb_rr u_rr (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_req0  (i_p0_req),
      .i_req1  (i_p1_req),
      .i_take  ((state_q == IDLE) && !i_reset),
      .o_gnt0  (gnt0),
      .o_gnt1  (gnt1)
   );

`ifdef IMEM_ARBITER_CWF_EN
   assign p0_start = i_p0_addr;
`else
   assign p0_start = i_p0_addr & ~ADDR_WIDTH'(LINE_WORDS - 1);
`endif

   // P0 word index wraps inside the line; the line base never changes mid-burst.
   assign word_idx   = start_q[IDX_W-1:0] + cnt_q;
   assign burst_addr = (port_q == P0) ? {start_q[ADDR_WIDTH-1:IDX_W], word_idx} : start_q;
   assign last_beat  = (port_q == P1) || (cnt_q == IDX_W'(LINE_WORDS - 1));

   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      start_d    = start_q;
      cnt_d      = cnt_q;
      p0_valid_d = 1'b0;
      p0_last_d  = 1'b0;
      p0_widx_d  = p0_widx_q;
      p0_data_d  = p0_data_q;
      p1_valid_d = 1'b0;
      p1_data_d  = p1_data_q;
      mem_addr   = '0;
      case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               state_d = XFER;
               port_d  = gnt0 ? P0 : P1;
               start_d = gnt0 ? p0_start : i_p1_addr;
               cnt_d   = '0;
            end
         end
         XFER: begin
            mem_addr = burst_addr;
            if (port_q == P0) begin
               p0_valid_d = 1'b1;
               p0_data_d  = i_mem_data;
               p0_widx_d  = word_idx;
               p0_last_d  = last_beat;
            end else begin
               p1_valid_d = 1'b1;
               p1_data_d  = i_mem_data;
            end
            if (last_beat) begin
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= IDLE;
         port_q     <= P0;
         start_q    <= '0;
         cnt_q      <= '0;
         p0_valid_q <= 1'b0;
         p0_last_q  <= 1'b0;
         p0_widx_q  <= '0;
         p0_data_q  <= '0;
         p1_valid_q <= 1'b0;
         p1_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         start_q    <= start_d;
         cnt_q      <= cnt_d;
         p0_valid_q <= p0_valid_d;
         p0_last_q  <= p0_last_d;
         p0_widx_q  <= p0_widx_d;
         p0_data_q  <= p0_data_d;
         p1_valid_q <= p1_valid_d;
         p1_data_q  <= p1_data_d;
      end
   end

   assign o_p0_gnt    = gnt0;
   assign o_p1_gnt    = gnt1;
   assign o_p0_valid  = p0_valid_q;
   assign o_p0_last   = p0_last_q;
   assign o_p0_widx   = p0_widx_q;
   assign o_p0_data   = p0_data_q;
   assign o_p1_valid  = p1_valid_q;
   assign o_p1_data   = p1_data_q;
   assign o_mem_addr  = mem_addr;
   assign o_busy      = (state_q != IDLE);
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: transaction-level timeline model (grant cycle G,
// addresses G+1..G+len, data G+2..G+len+1), directed scenarios and random traffic.
module tb_imem_arbiter;
   import imem_arbiter_pkg::*;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int IW = 2;
`ifdef IMEM_ARBITER_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic          i_clock = 1'b0;
   logic          i_reset;
   logic          i_p0_req, i_p1_req;
   logic [AW-1:0] i_p0_addr, i_p1_addr;
   logic          o_p0_gnt, o_p0_valid, o_p0_last, o_p1_gnt, o_p1_valid, o_busy;
   logic [DW-1:0] o_p0_data, o_p1_data, i_mem_data;
   logic [IW-1:0] o_p0_widx;
   logic [AW-1:0] o_mem_addr;
   ArbState       o_dbg_state;

   always #5 i_clock = ~i_clock;

   // ROM image: word[a] = a
   assign i_mem_data = DW'(o_mem_addr);

   imem_arbiter dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .i_p0_req(i_p0_req), .i_p0_addr(i_p0_addr), .o_p0_gnt(o_p0_gnt),
      .o_p0_valid(o_p0_valid), .o_p0_last(o_p0_last), .o_p0_data(o_p0_data),
      .o_p0_widx(o_p0_widx), .i_p1_req(i_p1_req), .i_p1_addr(i_p1_addr),
      .o_p1_gnt(o_p1_gnt), .o_p1_valid(o_p1_valid), .o_p1_data(o_p1_data),
      .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_busy(o_busy),
      .o_dbg_state(o_dbg_state)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: one active burst described by grant cycle, port, start, length.
   bit armed = 1'b0, rst_prev = 1'b0;
   bit b_act = 1'b0;
   int b_g, b_port, b_len, b_start;
   int last_served = 1;
   int free_at = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int b_addr(input int k);
      if (b_port == 1) return b_start;
      return (b_start & ~(LW - 1)) | ((b_start + k) % LW);
   endfunction

   task automatic step(input bit rst, input bit r0, input int a0, input bit r1, input int a1,
                       output bit g0, output bit g1);
      int d, k, win, e_st, e_maddr, e_data, e_widx;
      bit e_v0, e_v1, e_last, e_busy, e_g0, e_g1;
      @(posedge i_clock);
      #1;
      i_reset = rst; i_p0_req = r0; i_p0_addr = AW'(a0); i_p1_req = r1; i_p1_addr = AW'(a1);
      #1;
      e_st = 0; e_maddr = 0; e_data = 0; e_widx = 0;
      e_v0 = 0; e_v1 = 0; e_last = 0; e_busy = 0; e_g0 = 0; e_g1 = 0;
      if (b_act) begin
         d = cyc - b_g;
         if (d >= 1 && d <= b_len) begin
            e_st = 1; e_busy = 1; e_maddr = b_addr(d - 1);
         end else if (d == b_len + 1) begin
            e_st = 2; e_busy = 1;
         end
         if (d >= 2 && d <= b_len + 1) begin
            k = d - 2;
            e_data = b_addr(k);
            e_widx = e_data % LW;
            if (b_port == 0) begin
               e_v0 = 1; e_last = (k == b_len - 1);
            end else begin
               e_v1 = 1;
            end
         end
      end
      if (!rst && cyc >= free_at && (r0 || r1)) begin
         win = (r0 && r1) ? ((last_served == 1) ? 0 : 1) : (r0 ? 0 : 1);
         e_g0 = (win == 0); e_g1 = (win == 1);
         b_act = 1; b_g = cyc; b_port = win; b_len = (win == 0) ? LW : 1;
         b_start = (win == 1) ? a1 : (CWF ? a0 : (a0 & ~(LW - 1)));
         last_served = win;
         free_at = cyc + b_len + 2;
      end
      if (armed) begin
         chk("p0_gnt", 32'(o_p0_gnt), 32'(e_g0));
         chk("p1_gnt", 32'(o_p1_gnt), 32'(e_g1));
         chk("p0_valid", 32'(o_p0_valid), 32'(e_v0));
         chk("p1_valid", 32'(o_p1_valid), 32'(e_v1));
         chk("p0_last", 32'(o_p0_last), 32'(e_last));
         chk("busy", 32'(o_busy), 32'(e_busy));
         chk("state", 32'(o_dbg_state), 32'(e_st));
         if (e_st != 2) chk("mem_addr", 32'(o_mem_addr), 32'(e_maddr));
         if (e_v0) begin
            chk("p0_data", o_p0_data, 32'(e_data));
            chk("p0_widx", 32'(o_p0_widx), 32'(e_widx));
         end
         if (e_v1) chk("p1_data", o_p1_data, 32'(e_data));
         if (rst_prev) begin
            chk("rst_p0_data", o_p0_data, 32'd0);
            chk("rst_p1_data", o_p1_data, 32'd0);
         end
      end
      g0 = o_p0_gnt;
      g1 = o_p1_gnt;
      if (rst) begin
         b_act = 0; last_served = 1; free_at = cyc + 1; armed = 1;
      end
      rst_prev = rst;
      cyc++;
   endtask

   task automatic idle(input int n);
      bit g0, g1;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, g0, g1);
   endtask

   // Line refill of 0x012: fixed data/widx sequence against constants.
   task automatic line_directed();
      bit g0, g1;
      int v;
      exp_q.delete(); got_q.delete();
      if (CWF) exp_q = '{32'h012, 32'h013, 32'h010, 32'h011};
      else     exp_q = '{32'h010, 32'h011, 32'h012, 32'h013};
      step(0, 1, 'h012, 0, 0, g0, g1);
      chk("line_gnt", 32'(g0), 32'd1);
      v = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0, g0, g1);
         if (o_p0_valid) begin
            got_q.push_back(o_p0_data);
            chk("line_widx", 32'(o_p0_widx), exp_q[v] & 32'h3);
            chk("line_last", 32'(o_p0_last), 32'(v == 3));
            v++;
         end
      end
      chk("line_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) chk("line_data", got_q[i], exp_q[i]);
   endtask

   // Reset during the 2nd P0 data word, then a fresh burst completes.
   task automatic reset_mid_burst();
      bit g0, g1;
      int nv;
      step(0, 1, 'h020, 0, 0, g0, g1);
      step(0, 0, 0, 0, 0, g0, g1);
      step(0, 0, 0, 0, 0, g0, g1);
      step(1, 0, 0, 0, 0, g0, g1);
      chk("mid_valid_before_rst", 32'(o_p0_valid), 32'd1);
      step(0, 0, 0, 0, 0, g0, g1);
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      chk("mid_rst_valid", 32'(o_p0_valid), 32'd0);
      step(0, 1, 'h035, 0, 0, g0, g1);
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0, g0, g1);
         if (o_p0_valid) nv++;
      end
      chk("mid_new_burst_words", 32'(nv), 32'd4);
   endtask

   // Both request out of reset: P0 first, P1 granted at G+6, valid at G+8.
   task automatic both_from_reset();
      bit g0, g1;
      int p1_gnt_at, p1_val_at, r1;
      logic [31:0] p1d;
      step(1, 0, 0, 0, 0, g0, g1);
      step(0, 1, 'h010, 1, 'hF11, g0, g1);
      chk("both_first_p0", 32'(g0), 32'd1);
      p1_gnt_at = -1; p1_val_at = -1; r1 = 1; p1d = 0;
      for (int i = 1; i <= 10; i++) begin
         step(0, 0, 0, r1[0], 'hF11, g0, g1);
         if (g1) begin p1_gnt_at = i; r1 = 0; end
         if (o_p1_valid && p1_val_at < 0) begin p1_val_at = i; p1d = o_p1_data; end
      end
      chk("both_p1_gnt_offset", 32'(p1_gnt_at), 32'd6);
      chk("both_p1_valid_offset", 32'(p1_val_at), 32'd8);
      chk("both_p1_data", p1d, 32'hF11);
   endtask

   // Single P1 word read: busy exactly two cycles, P0 untouched.
   task automatic p1_single();
      bit g0, g1;
      int nb, nv0, nv1;
      logic [31:0] d;
      step(0, 0, 0, 1, 'hFFF, g0, g1);
      chk("p1s_gnt", 32'(g1), 32'd1);
      nb = 0; nv0 = 0; nv1 = 0; d = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0, g0, g1);
         nb += int'(o_busy);
         nv0 += int'(o_p0_valid);
         if (o_p1_valid) begin nv1++; d = o_p1_data; end
      end
      chk("p1s_busy_cycles", 32'(nb), 32'd2);
      chk("p1s_p0_valid", 32'(nv0), 32'd0);
      chk("p1s_valid_count", 32'(nv1), 32'd1);
      chk("p1s_data", d, 32'hFFF);
   endtask

   task automatic run_random(input int n, input int pct, input bit hold);
      bit p0p, p1p, g0, g1, rst, have_prev, prev1;
      int a0, a1;
      p0p = 0; p1p = 0; a0 = 0; a1 = 0; have_prev = 0; prev1 = 0;
      for (int i = 0; i < n; i++) begin
         if (!p0p && $urandom_range(0, 99) < pct) begin p0p = 1; a0 = $urandom_range(0, 4095); end
         if (!p1p && $urandom_range(0, 99) < pct) begin p1p = 1; a1 = $urandom_range(0, 4095); end
         if (!hold && p0p && $urandom_range(0, 99) < 3) p0p = 0;
         if (!hold && p1p && $urandom_range(0, 99) < 3) p1p = 0;
         rst = !hold && ($urandom_range(0, 199) == 0);
         step(rst, p0p, a0, p1p, a1, g0, g1);
         if (g0) p0p = 0;
         if (g1) p1p = 0;
         if (hold && (g0 || g1)) begin
            if (have_prev) chk("alternate", 32'(g1), 32'(!prev1));
            prev1 = g1; have_prev = 1;
         end
      end
   endtask

   initial begin
      bit g0, g1;
      i_reset = 1'b1; i_p0_req = 1'b0; i_p1_req = 1'b0; i_p0_addr = '0; i_p1_addr = '0;
      step(1, 0, 0, 0, 0, g0, g1);
      step(1, 0, 0, 0, 0, g0, g1);
      idle(3);
      line_directed();
      idle(2);
      reset_mid_burst();
      idle(2);
      both_from_reset();
      idle(2);
      p1_single();
      run_random(500, 30, 1'b0);
      run_random(80, 100, 1'b1);
      run_random(500, 60, 1'b0);
      idle(8);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
